// File: rtl/dsp48a1_pkg.sv
// Shared constants and types for sequencing a DSP48A1 slice as a multiply-accumulate engine.
package dsp48a1_pkg;

   localparam int unsigned DATA_W     = 18;
   localparam int unsigned P_W        = 48;
   localparam int unsigned OPMODE_W   = 8;
   localparam int unsigned MUL_STAGES = 2;
   localparam int unsigned P_STAGES   = 1;

   localparam logic [1:0]  OPM_X_M    = 2'b01;
   localparam logic [1:0]  OPM_Z_ZERO = 2'b00;
   localparam logic [1:0]  OPM_Z_P    = 2'b10;
   localparam int unsigned OPM_SUB    = 7;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   typedef struct packed {
      logic valid;
      logic last;
   } vtag_t;

   // First product of a job starts from Z=0, later ones accumulate onto P.
   function automatic logic [OPMODE_W-1:0] opmode_for(input logic first, input logic sub);
      logic [OPMODE_W-1:0] opm;
      opm          = '0;
      opm[1:0]     = OPM_X_M;
      opm[3:2]     = first ? OPM_Z_ZERO : OPM_Z_P;
      opm[OPM_SUB] = sub;
      return opm;
   endfunction

endpackage

// File: rtl/dsp48a1_mac_vpipe.sv
// Valid/last tag shift pipe tracking operand pairs through the DSP A1/B1 and M stages.
module dsp48a1_mac_vpipe
   import dsp48a1_pkg::*;
(
   input  logic CLK,
   input  logic RSTB,
   input  logic flush,
   input  logic tag_valid,
   input  logic tag_last,
   output logic v1,
   output logic v2,
   output logic last2
);

   vtag_t pipe_q [MUL_STAGES];

   always_ff @(posedge CLK or posedge RSTB) begin
      if (RSTB) begin
         for (int i = 0; i < int'(MUL_STAGES); i++) pipe_q[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < int'(MUL_STAGES); i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= '{valid: tag_valid, last: tag_last};
         for (int i = 1; i < int'(MUL_STAGES); i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign v1    = pipe_q[0].valid;
   assign v2    = pipe_q[MUL_STAGES-1].valid;
   assign last2 = pipe_q[MUL_STAGES-1].last;

endmodule

// File: rtl/dsp48a1_mac_sequencer.sv
// Streams N operand pairs through one DSP48A1 slice and returns the 48-bit sum of products.
module dsp48a1_mac_sequencer
   import dsp48a1_pkg::*;
#(
   parameter int unsigned LEN_W = 16
) (
   input  logic                CLK,
   input  logic                RSTB,
   input  logic                abort,
   input  logic                start_valid,
   output logic                start_ready,
   input  logic [LEN_W-1:0]    start_len,
   input  logic                start_sub,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   in_a,
   input  logic [DATA_W-1:0]   in_b,
   output logic [DATA_W-1:0]   dsp_a,
   output logic [DATA_W-1:0]   dsp_b,
   output logic [OPMODE_W-1:0] dsp_opmode,
   output logic                dsp_cea,
   output logic                dsp_ceb,
   output logic                dsp_cem,
   output logic                dsp_cep,
   input  logic [P_W-1:0]      dsp_p,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [P_W-1:0]      res_data,
   output logic                busy
);

   state_t              state_q, state_d;
   logic [LEN_W-1:0]    rem_q;
   logic                sub_q, first_q;
   logic                accept, last_accept;
   logic                v1, v2, last2, p_done;
   logic [P_STAGES-1:0] p_last_q;

   // abort outranks an accept in the same cycle
   assign accept      = in_valid & in_ready & ~abort;
   assign last_accept = accept & (rem_q == LEN_W'(1));

   assign start_ready = (state_q == IDLE);
   assign in_ready    = (state_q == RUN) && (rem_q != '0);
   assign busy        = (state_q != IDLE);
   assign res_valid   = (state_q == DONE);
   assign dsp_a       = in_a;
   assign dsp_b       = in_b;
   assign dsp_cea     = accept;
   assign dsp_ceb     = accept;
   assign dsp_cem     = v1;
   assign dsp_cep     = v2;
   assign p_done      = p_last_q[P_STAGES-1];

   dsp48a1_mac_vpipe u_vpipe (
      .CLK       (CLK),
      .RSTB      (RSTB),
      .flush     (abort),
      .tag_valid (accept),
      .tag_last  (last_accept),
      .v1        (v1),
      .v2        (v2),
      .last2     (last2)
   );

   always_ff @(posedge CLK or posedge RSTB) begin
      if (RSTB) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (start_valid) state_d = (start_len == '0) ? DONE : RUN;
            RUN:     if (last_accept) state_d = DRAIN;
            DRAIN:   if (p_done)      state_d = DONE;
            DONE:    if (res_ready)   state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Job bookkeeping, OPMODE for the pair entering stage 1, and result capture.
   always_ff @(posedge CLK or posedge RSTB) begin
      if (RSTB) begin
         rem_q      <= '0;
         sub_q      <= 1'b0;
         first_q    <= 1'b0;
         dsp_opmode <= '0;
         res_data   <= '0;
         p_last_q   <= '0;
      end else begin
         p_last_q <= abort ? '0 : P_STAGES'({p_last_q, v2 & last2});
         if (!abort) begin
            if (state_q == IDLE && start_valid) begin
               rem_q   <= start_len;
               sub_q   <= start_sub;
               first_q <= 1'b1;
               if (start_len == '0) res_data <= '0;
            end
            if (accept) begin
               rem_q      <= rem_q - LEN_W'(1);
               first_q    <= 1'b0;
               dsp_opmode <= opmode_for(first_q, sub_q);
            end
            if (state_q == DRAIN && p_done) res_data <= dsp_p;
         end
      end
   end

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Bench for dsp48a1_mac_sequencer with a behavioural DSP48A1 slice (A1/B1, M, OPMODE and P registers).
module tb_dsp48a1_mac_sequencer;

   localparam int unsigned LEN_W = 16;
   localparam int unsigned MAX_N = 16;

   logic              CLK = 1'b0;
   logic              RSTB = 1'b1;
   logic              abort = 1'b0;
   logic              start_valid = 1'b0;
   logic              start_ready;
   logic [LEN_W-1:0]  start_len = '0;
   logic              start_sub = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [17:0]       in_a = '0;
   logic [17:0]       in_b = '0;
   logic [17:0]       dsp_a, dsp_b;
   logic [7:0]        dsp_opmode;
   logic              dsp_cea, dsp_ceb, dsp_cem, dsp_cep;
   logic [47:0]       dsp_p;
   logic              res_valid;
   logic              res_ready = 1'b0;
   logic [47:0]       res_data;
   logic              busy;

   int checks = 0;
   int errors = 0;
   logic [17:0] op_a [MAX_N];
   logic [17:0] op_b [MAX_N];

   always #5 CLK = ~CLK;

   dsp48a1_mac_sequencer #(.LEN_W(LEN_W)) dut (
      .CLK(CLK), .RSTB(RSTB), .abort(abort),
      .start_valid(start_valid), .start_ready(start_ready),
      .start_len(start_len), .start_sub(start_sub),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
      .dsp_cea(dsp_cea), .dsp_ceb(dsp_ceb), .dsp_cem(dsp_cem), .dsp_cep(dsp_cep),
      .dsp_p(dsp_p),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .busy(busy)
   );

   // DSP48A1 slice model: A1REG=B1REG=MREG=PREG=OPMODEREG=1, CEOPMODE=1, carry-in 0
   logic [17:0] a1_r, b1_r;
   logic [35:0] m_r;
   logic [7:0]  opm_r;
   logic [47:0] p_r, x_mux, z_mux;

   always_comb begin
      x_mux = (opm_r[1:0] == 2'b01) ? 48'(m_r) : 48'd0;
      z_mux = (opm_r[3:2] == 2'b10) ? p_r : 48'd0;
   end

   always_ff @(posedge CLK or posedge RSTB) begin
      if (RSTB) begin
         a1_r <= '0; b1_r <= '0; m_r <= '0; opm_r <= '0; p_r <= '0;
      end else begin
         if (dsp_cea) a1_r <= dsp_a;
         if (dsp_ceb) b1_r <= dsp_b;
         if (dsp_cem) m_r <= 36'(a1_r) * 36'(b1_r);
         opm_r <= dsp_opmode;
         if (dsp_cep) p_r <= opm_r[7] ? (z_mux - x_mux) : (z_mux + x_mux);
      end
   end
   assign dsp_p = p_r;

   // vmode: 0 continuous, 1 alternating bubbles, 2 random bubbles; abort_at < 0 means no abort
   task automatic run_job(input string tag, input int n, input logic sub, input int vmode,
                          input int abort_at, input int rdy_delay);
      logic [47:0] exp_sum;
      logic [7:0]  exp_opm;
      int idx, cyc, last_cyc, lat, ceps, cems, ces, held, dropped;
      bit phase, aborted, got, acc, exp_rdy;
      exp_sum = '0;
      for (int i = 0; i < n; i++) exp_sum += 48'(op_a[i]) * 48'(op_b[i]);
      if (sub) exp_sum = -exp_sum;

      start_valid = 1'b1; start_len = LEN_W'(n); start_sub = sub;
      @(negedge CLK);
      start_valid = 1'b0;
      idx = 0; cyc = 0; last_cyc = -1; lat = 0; ceps = 0; cems = 0; ces = 0;
      phase = 1'b1; aborted = 1'b0; got = 1'b0;
      while (!got && !aborted && cyc < 8*n + 40) begin
         if (idx < n) begin
            case (vmode)
               0:       in_valid = 1'b1;
               1:       in_valid = phase;
               default: in_valid = 1'($urandom_range(0, 1));
            endcase
            phase = !phase;
            in_a = op_a[idx]; in_b = op_b[idx];
            abort = (idx == abort_at) && in_valid;
            start_valid = 1'($urandom_range(0, 1));
            start_len = LEN_W'($urandom_range(0, 5));
         end else begin
            in_valid = 1'b0; abort = 1'b0; start_valid = 1'b0;
            in_a = 18'($urandom); in_b = 18'($urandom);
         end
         #1;
         exp_rdy = (idx < n);
         acc = in_valid && exp_rdy && !abort;
         checks++;
         if (in_ready !== exp_rdy || dsp_cea !== acc || dsp_ceb !== acc) begin
            errors++;
            $display("FAIL %s handshake cyc %0d: in_ready=%b cea=%b ceb=%b, expected in_ready=%b ce=%b",
                     tag, cyc, in_ready, dsp_cea, dsp_ceb, exp_rdy, acc);
         end
         if (dsp_cem) begin
            exp_opm = {sub, 3'b000, (cems == 0) ? 4'h1 : 4'h9};
            checks++;
            if (dsp_opmode !== exp_opm) begin
               errors++;
               $display("FAIL %s opmode pair %0d: got %h expected %h", tag, cems, dsp_opmode, exp_opm);
            end
            cems++;
         end
         if (dsp_cep) ceps++;
         if (dsp_cea || dsp_ceb || dsp_cem || dsp_cep) ces++;
         if (res_valid) begin
            got = 1'b1;
            lat = cyc - last_cyc;
         end else begin
            if (acc) begin
               last_cyc = cyc;
               idx++;
            end
            if (abort) aborted = 1'b1;
            @(negedge CLK);
            abort = 1'b0;
            cyc++;
         end
      end
      in_valid = 1'b0;
      start_valid = 1'b0;

      if (abort_at >= 0) begin
         checks++;
         if (!aborted || busy !== 1'b0 || start_ready !== 1'b1 || in_ready !== 1'b0 ||
             dsp_cem !== 1'b0 || dsp_cep !== 1'b0) begin
            errors++;
            $display("FAIL %s abort: aborted=%b busy=%b start_ready=%b in_ready=%b cem=%b cep=%b, expected 1 0 1 0 0 0",
                     tag, aborted, busy, start_ready, in_ready, dsp_cem, dsp_cep);
         end
         dropped = 0;
         for (int k = 0; k < 6; k++) begin
            if (res_valid !== 1'b0 || dsp_cep !== 1'b0) dropped++;
            @(negedge CLK);
         end
         checks++;
         if (dropped != 0) begin
            errors++;
            $display("FAIL %s post-abort: %0d cycles with res_valid/cep set, expected 0", tag, dropped);
         end
         return;
      end

      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s timeout: res_valid=%b after %0d cycles, expected 1", tag, res_valid, cyc);
         abort = 1'b1;
         @(negedge CLK);
         abort = 1'b0;
         return;
      end
      checks++;
      if (res_data !== exp_sum) begin
         errors++;
         $display("FAIL %s res_data: got %h expected %h", tag, res_data, exp_sum);
      end
      checks++;
      if (lat != ((n == 0) ? 1 : 4)) begin
         errors++;
         $display("FAIL %s latency: got %0d expected %0d", tag, lat, (n == 0) ? 1 : 4);
      end
      checks++;
      if (ceps != n || cems != n || (n == 0 && ces != 0)) begin
         errors++;
         $display("FAIL %s enables: cep=%0d cem=%0d any_ce=%0d, expected cep=cem=%0d", tag, ceps, cems, ces, n);
      end
      held = 0;
      for (int k = 0; k < rdy_delay; k++) begin
         @(negedge CLK);
         if (res_valid !== 1'b1 || res_data !== exp_sum) held++;
      end
      if (rdy_delay > 0) begin
         checks++;
         if (held != 0) begin
            errors++;
            $display("FAIL %s hold: %0d of %0d cycles lost result, expected 0", tag, held, rdy_delay);
         end
      end
      res_ready = 1'b1;
      @(negedge CLK);
      res_ready = 1'b0;
      checks++;
      if (res_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s release: res_valid=%b start_ready=%b busy=%b, expected 0 1 0",
                  tag, res_valid, start_ready, busy);
      end
   endtask

   task automatic test_reset();
      checks++;
      if (start_ready !== 1'b1 || in_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 ||
          dsp_cea !== 1'b0 || dsp_ceb !== 1'b0 || dsp_cem !== 1'b0 || dsp_cep !== 1'b0) begin
         errors++;
         $display("FAIL reset ctl: sr=%b ir=%b rv=%b busy=%b ce=%b%b%b%b, expected 1 0 0 0 0000",
                  start_ready, in_ready, res_valid, busy, dsp_cea, dsp_ceb, dsp_cem, dsp_cep);
      end
      checks++;
      if (res_data !== 48'd0 || dsp_opmode !== 8'h00) begin
         errors++;
         $display("FAIL reset data: res_data=%h opmode=%h, expected 0 00", res_data, dsp_opmode);
      end
   endtask

   task automatic test_basic();
      for (int i = 0; i < 4; i++) begin
         op_a[i] = 18'(i + 1);
         op_b[i] = 18'(i + 5);
      end
      run_job("basic", 4, 1'b0, 0, -1, 0);
   endtask

   task automatic test_bubbles();
      run_job("bubbles", 4, 1'b0, 1, -1, 2);
   endtask

   task automatic test_sub();
      op_a[0] = 18'd3; op_b[0] = 18'd5;
      run_job("sub", 1, 1'b1, 0, -1, 1);
   endtask

   task automatic test_zero_len();
      run_job("zero_len", 0, 1'b0, 0, -1, 10);
   endtask

   task automatic test_abort();
      for (int i = 0; i < 8; i++) begin
         op_a[i] = 18'($urandom);
         op_b[i] = 18'($urandom);
      end
      run_job("abort", 8, 1'b0, 0, 1, 0);
      op_a[0] = 18'd2; op_b[0] = 18'd3;
      op_a[1] = 18'd4; op_b[1] = 18'd5;
      run_job("after_abort", 2, 1'b0, 0, -1, 0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         op_a[i] = 18'($urandom);
         op_b[i] = 18'($urandom);
      end
      run_job("b2b_first", 3, 1'b1, 0, -1, 0);
      run_job("b2b_second", 3, 1'b0, 0, -1, 0);
   endtask

   task automatic test_random();
      int n;
      for (int j = 0; j < 10; j++) begin
         n = int'($urandom_range(1, 12));
         for (int i = 0; i < n; i++) begin
            op_a[i] = 18'($urandom);
            op_b[i] = 18'($urandom);
         end
         run_job("random", n, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), -1,
                 int'($urandom_range(0, 3)));
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 4; i++) begin
         op_a[i] = 18'($urandom_range(1, 1000));
         op_b[i] = 18'($urandom_range(1, 1000));
      end
      start_valid = 1'b1; start_len = LEN_W'(4); start_sub = 1'b0;
      @(negedge CLK);
      start_valid = 1'b0;
      in_valid = 1'b1; in_a = op_a[0]; in_b = op_b[0];
      @(negedge CLK);
      in_a = op_a[1]; in_b = op_b[1];
      @(negedge CLK);
      #2 RSTB = 1'b1;
      #1;
      checks++;
      if (start_ready !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0 ||
          dsp_cea !== 1'b0 || dsp_ceb !== 1'b0 || dsp_cem !== 1'b0 || dsp_cep !== 1'b0) begin
         errors++;
         $display("FAIL async_reset ctl: sr=%b ir=%b busy=%b rv=%b ce=%b%b%b%b, expected 1 0 0 0 0000",
                  start_ready, in_ready, busy, res_valid, dsp_cea, dsp_ceb, dsp_cem, dsp_cep);
      end
      checks++;
      if (res_data !== 48'd0 || dsp_opmode !== 8'h00) begin
         errors++;
         $display("FAIL async_reset data: res_data=%h opmode=%h, expected 0 00", res_data, dsp_opmode);
      end
      in_valid = 1'b0;
      @(negedge CLK);
      RSTB = 1'b0;
      @(negedge CLK);
      run_job("post_reset", 4, 1'b0, 0, -1, 0);
   endtask

   initial begin
      repeat (3) @(negedge CLK);
      RSTB = 1'b0;
      @(negedge CLK);
      test_reset();
      test_basic();
      test_bubbles();
      test_sub();
      test_zero_len();
      test_abort();
      test_back_to_back();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
